// File: rtl/calc_controller_pkg.sv
// Shared definitions for the four-digit calculator controller: operator codes,
// FSM state encoding, operand width and the double-dabble step used by bin2bcd.
package calc_controller_pkg;

  localparam int OPW  = 14;
  localparam int DIGW = 4;
  localparam logic [3:0] ERR_CODE_DEFAULT = 4'hE;
  localparam logic [3:0] DIV_LAST         = 4'd13;
  localparam logic [3:0] CONV_LAST        = 4'd13;
  localparam logic [2*OPW-1:0] MAX_VALUE  = 28'd9999;

  typedef enum logic [2:0] {
    OPT_ADD = 3'd0,
    OPT_SUB = 3'd1,
    OPT_MUL = 3'd2,
    OPT_DIV = 3'd3,
    OPT_CLR = 3'd4
  } opt_e;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_CONVERT = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // One double-dabble iteration on {bcd[15:0], bin[13:0]}: add 3 to BCD nibbles >= 5, then shift left.
  function automatic logic [4*DIGW+OPW-1:0] dd_step(input logic [4*DIGW+OPW-1:0] v);
    logic [4*DIGW+OPW-1:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (t[OPW+4*i +: 4] >= 4'd5) begin
        t[OPW+4*i +: 4] = t[OPW+4*i +: 4] + 4'd3;
      end else begin
        t[OPW+4*i +: 4] = t[OPW+4*i +: 4];
      end
    end
    return {t[4*DIGW+OPW-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/calc_controller_if.sv
// Keypad event and LED display bundle between the keypad decoder and the calculator controller.
interface calc_controller_if;
  import calc_controller_pkg::*;

  logic [3:0]      num;
  logic            numPressed;
  logic [2:0]      opt;
  logic            optPressed;
  logic            submit;
  logic [DIGW-1:0] digit1;
  logic [DIGW-1:0] digit2;
  logic [DIGW-1:0] digit3;
  logic [DIGW-1:0] digit4;
  logic            busy;
  logic            error;

  modport master (
    output num, numPressed, opt, optPressed, submit,
    input  digit1, digit2, digit3, digit4, busy, error
  );

  modport slave (
    input  num, numPressed, opt, optPressed, submit,
    output digit1, digit2, digit3, digit4, busy, error
  );

endinterface

// File: rtl/calc_controller_bin2bcd.sv
// Iterative 14-bit binary to 4-digit BCD converter; the first shift happens on the
// start edge, so done is high in the cycle after the 14th shift.
module calc_controller_bin2bcd
  import calc_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OPW-1:0]    bin,
  output logic              done,
  output logic [4*DIGW-1:0] bcd
);

  logic [4*DIGW+OPW-1:0] sh_q, sh_d, step_s;
  logic [3:0]            cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic                  done_q, done_d;

  // Next shift-register contents and iteration count
  always_comb begin
    step_s = dd_step(start ? {{(4*DIGW){1'b0}}, bin} : sh_q);
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      sh_d  = step_s;
      cnt_d = 4'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      sh_d  = step_s;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == CONV_LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        run_d  = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Converter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      cnt_q  <= 4'd0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = sh_q[4*DIGW+OPW-1:OPW];

endmodule

// File: rtl/calc_controller.sv
// Four-digit keypad calculator: operand entry, inline restoring divider, ADD/SUB/MUL,
// range checking and BCD display via the bin2bcd sub-module.
module calc_controller
  import calc_controller_pkg::*;
#(
  parameter logic [3:0] ERR_CODE = ERR_CODE_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  calc_controller_if.slave kb
);

  state_e              state_q, state_d;
  opt_e                op_q, op_d;
  logic [OPW-1:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic [OPW-1:0]      quo_q, quo_d, rem_q, rem_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [3:0]          dcnt_q, dcnt_d;
  logic [4*DIGW-1:0]   digits_q, digits_d;
  logic                busy_q, busy_d, error_q, error_d;

  logic                ev_clr_s, ev_sub_s, ev_ari_s, ev_dig_s, opt_valid_s, room_s;
  logic [OPW-1:0]      ext_a_s, ext_b_s, num_ext_s;
  logic [4*DIGW-1:0]   dig_push_s;
  logic [OPW:0]        rem_sh_s, rem_sub_s;
  logic                div_ge_s;
  logic [2*OPW-1:0]    wide_s;
  logic                fin_s, fin_err_s;
  logic [OPW-1:0]      fin_val_s;
  logic                conv_start_s, conv_done_s;
  logic [4*DIGW-1:0]   conv_bcd_s;

  // Keypad event decode; at most one event survives per cycle (CLR > submit > opt > digit)
  always_comb begin
    opt_valid_s = kb.optPressed && (kb.opt <= 3'd4);
    ev_clr_s    = kb.optPressed && (kb.opt == OPT_CLR);
    ev_sub_s    = kb.submit && !ev_clr_s;
    ev_ari_s    = kb.optPressed && (kb.opt < 3'd4) && !kb.submit;
    ev_dig_s    = kb.numPressed && (kb.num <= 4'd9) && !kb.submit && !opt_valid_s;
    room_s      = (cnt_q < 3'd4);
    num_ext_s   = {{(OPW-4){1'b0}}, kb.num};
    ext_a_s     = (a_q * 14'd10) + num_ext_s;
    ext_b_s     = (b_q * 14'd10) + num_ext_s;
    dig_push_s  = (cnt_q == 3'd0) ? {12'd0, kb.num} : {digits_q[11:0], kb.num};
  end

  // Arithmetic datapath: one restoring-division step per cycle, or a single-cycle ALU result
  always_comb begin
    rem_sh_s  = {rem_q, quo_q[OPW-1]};
    rem_sub_s = rem_sh_s - {1'b0, b_q};
    div_ge_s  = !rem_sub_s[OPW];
    case (op_q)
      OPT_ADD: wide_s = {{OPW{1'b0}}, a_q} + {{OPW{1'b0}}, b_q};
      OPT_SUB: wide_s = {{OPW{1'b0}}, a_q} - {{OPW{1'b0}}, b_q};
      OPT_MUL: wide_s = {{OPW{1'b0}}, a_q} * {{OPW{1'b0}}, b_q};
      default: wide_s = {(2*OPW){1'b0}};
    endcase
    if (op_q == OPT_DIV) begin
      fin_s     = (dcnt_q == DIV_LAST);
      fin_val_s = {quo_q[OPW-2:0], div_ge_s};
      fin_err_s = (b_q == 14'd0);
    end else begin
      fin_s     = 1'b1;
      fin_val_s = wide_s[OPW-1:0];
      fin_err_s = ((op_q == OPT_SUB) && (b_q > a_q)) || (wide_s > MAX_VALUE);
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    dcnt_d       = dcnt_q;
    digits_d     = digits_q;
    conv_start_s = 1'b0;

    if (ev_clr_s && (state_q != ST_COMPUTE) && (state_q != ST_CONVERT)) begin
      state_d  = ST_ENTER_A;
      op_d     = OPT_ADD;
      a_d      = '0;
      b_d      = '0;
      cnt_d    = 3'd0;
      digits_d = '0;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (ev_ari_s) begin
            op_d    = opt_e'(kb.opt);
            b_d     = '0;
            cnt_d   = 3'd0;
            state_d = ST_ENTER_B;
          end else if (ev_dig_s && room_s) begin
            a_d      = ext_a_s;
            cnt_d    = cnt_q + 3'd1;
            digits_d = dig_push_s;
          end else begin
            state_d = ST_ENTER_A;
          end
        end
        ST_ENTER_B: begin
          if (ev_sub_s) begin
            quo_d   = a_q;
            rem_d   = '0;
            dcnt_d  = 4'd0;
            state_d = ST_COMPUTE;
          end else if (ev_ari_s && (cnt_q == 3'd0)) begin
            op_d = opt_e'(kb.opt);
          end else if (ev_dig_s && room_s) begin
            b_d      = ext_b_s;
            cnt_d    = cnt_q + 3'd1;
            digits_d = dig_push_s;
          end else begin
            state_d = ST_ENTER_B;
          end
        end
        ST_COMPUTE: begin
          if (op_q == OPT_DIV) begin
            quo_d  = fin_val_s;
            rem_d  = div_ge_s ? rem_sub_s[OPW-1:0] : rem_sh_s[OPW-1:0];
            dcnt_d = dcnt_q + 4'd1;
          end else begin
            dcnt_d = dcnt_q;
          end
          if (fin_s && fin_err_s) begin
            digits_d = {4{ERR_CODE}};
            state_d  = ST_ERROR;
          end else if (fin_s) begin
            res_d        = fin_val_s;
            conv_start_s = 1'b1;
            state_d      = ST_CONVERT;
          end else begin
            state_d = ST_COMPUTE;
          end
        end
        ST_CONVERT: begin
          if (conv_done_s) begin
            digits_d = conv_bcd_s;
            state_d  = ST_RESULT;
          end else begin
            state_d = ST_CONVERT;
          end
        end
        ST_RESULT: begin
          // A chained operator continues from the result, which is already on display
          if (ev_ari_s) begin
            a_d     = res_q;
            b_d     = '0;
            op_d    = opt_e'(kb.opt);
            cnt_d   = 3'd0;
            state_d = ST_ENTER_B;
          end else if (ev_dig_s) begin
            a_d      = num_ext_s;
            b_d      = '0;
            cnt_d    = 3'd1;
            digits_d = {12'd0, kb.num};
            state_d  = ST_ENTER_A;
          end else begin
            state_d = ST_RESULT;
          end
        end
        ST_ERROR: begin
          if (ev_dig_s) begin
            a_d      = num_ext_s;
            b_d      = '0;
            cnt_d    = 3'd1;
            digits_d = {12'd0, kb.num};
            state_d  = ST_ENTER_A;
          end else begin
            state_d = ST_ERROR;
          end
        end
        default: begin
          state_d = ST_ENTER_A;
        end
      endcase
    end

    busy_d  = (state_d == ST_COMPUTE) || (state_d == ST_CONVERT);
    error_d = (state_d == ST_ERROR);
  end

  // Controller state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ENTER_A;
      op_q     <= OPT_ADD;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= 3'd0;
      dcnt_q   <= 4'd0;
      digits_q <= '0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  calc_controller_bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (reset),
    .start (conv_start_s),
    .bin   (fin_val_s),
    .done  (conv_done_s),
    .bcd   (conv_bcd_s)
  );

  assign kb.digit1 = digits_q[15:12];
  assign kb.digit2 = digits_q[11:8];
  assign kb.digit3 = digits_q[7:4];
  assign kb.digit4 = digits_q[3:0];
  assign kb.busy   = busy_q;
  assign kb.error  = error_q;

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 Parameter: ERR_CODE, default 4'hE, digit code driven on all four digits in error state.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 num  input  4  decoded key value; valid only with numPressed.
REQ-005 numPressed  input  1  one-cycle pulse, digit key pressed.
REQ-006 opt  input  3  operator code; valid only with optPressed.
REQ-007 optPressed  input  1  one-cycle pulse, operator key pressed.
REQ-008 submit  input  1  one-cycle pulse, "=" key pressed.
REQ-009 digit1..digit4  output  4 each  display digits to the LED driver; digit1 most significant, zero-padded.
REQ-010 busy  output  1  high during COMPUTE and CONVERT.
REQ-011 error  output  1  high in ERROR state.

Function
REQ-012 States SHALL be ENTER_A, ENTER_B, COMPUTE, CONVERT, RESULT, ERROR.
REQ-013 Operands SHALL be held as 14-bit binary (0..9999); each accepted digit: operand <= operand*10 + num.
REQ-014 num > 9 SHALL be ignored; a 5th digit into a 4-digit operand SHALL be ignored.
REQ-015 Opt codes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 CLR; codes 5-7 SHALL be ignored.
REQ-016 Event priority within one cycle: CLR > submit > other opt > numPressed; lower-priority events that cycle SHALL be dropped.
REQ-017 CLR SHALL return to ENTER_A with both operands and digits zero, from any non-busy state.
REQ-018 ENTER_A: digit extends A; arithmetic opt latches operator, B<=0, goes ENTER_B; submit ignored.
REQ-019 ENTER_B: digit extends B; arithmetic opt before any B digit replaces operator, after a B digit is ignored; submit goes COMPUTE.
REQ-020 Display SHALL show A in ENTER_A and ENTER_B-before-first-digit, B once a B digit is entered, the result in RESULT.
REQ-021 COMPUTE SHALL last 1 cycle for ADD/SUB/MUL and exactly 14 cycles for DIV (restoring, quotient only, remainder discarded).
REQ-022 CONVERT SHALL last exactly 14 cycles (double-dabble); digits update on the CONVERT->RESULT edge.
REQ-023 Latency submit-sampled edge to digits valid: 15 cycles ADD/SUB/MUL, 28 cycles DIV.
REQ-024 Result > 9999, SUB result < 0, or DIV by 0 SHALL go ERROR after COMPUTE, skipping CONVERT; digits = ERR_CODE.
REQ-025 All keyboard events including CLR SHALL be ignored while busy.
REQ-026 RESULT: arithmetic opt SHALL load result into A and go ENTER_B; digit SHALL start new A with that digit in ENTER_A; submit ignored.
REQ-027 ERROR: only CLR or a digit exits; digit starts new A as in REQ-026.

Reset
REQ-028 On reset: state ENTER_A, A=B=0, operator ADD, digits 0, busy 0, error 0, immediately and asynchronously.
REQ-029 Reset mid-COMPUTE/CONVERT SHALL abort the operation; no stale result appears after release.

Structure
REQ-030 Shared package SHALL hold opt code constants, state encoding, ERR_CODE default, operand width 14.
REQ-031 One sub-module bin2bcd (14-bit iterative double-dabble, start/done handshake, 14 cycles) SHALL perform CONVERT.
REQ-032 Divider SHALL be inline in calc_controller.

Verification
REQ-033 Keys 1,2,ADD,3,4,submit -> busy 15 cycles, digits 0,0,4,6.
REQ-034 Keys 9,9,9,9,MUL,2,submit -> ERROR after 1 busy cycle, all digits 4'hE, error=1.
REQ-035 Keys 1,0,0,DIV,7,submit -> busy 28 cycles, digits 0,0,1,4; then DIV,2,submit -> digits 0,0,0,7.
REQ-036 Keys 5,SUB,8,submit -> ERROR; then digit 3 -> digits 0,0,0,3, error=0.
REQ-037 Keys 1,2,3,4,5 -> digits 1,2,3,4; numPressed+optPressed(CLR) same cycle -> all zero, ENTER_A.
REQ-038 Reset asserted 5 cycles into CONVERT -> digits 0, busy 0 at once; no result after release.
